// File: rtl/ibex_ipm_mul_pkg.sv
// Shared types and constants for the iterative GF(2^8) IPM multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ibex_ipm_mul_pkg;

    typedef enum logic [1:0] {
        IPM_OP_MUL = 2'b00,
        IPM_OP_SQR = 2'b01,
        IPM_OP_IP  = 2'b10
    } ipm_op_e;

    typedef enum logic [1:0] {
        IPM_IDLE = 2'b00,
        IPM_CALC = 2'b01,
        IPM_DONE = 2'b10
    } ipm_state_e;

    // Low byte of x^8+x^4+x^3+x+1; x^8 folds back onto these terms.
    localparam logic [7:0] IPM_GF_POLY = 8'h1B;

    // Multiply by x in GF(2^8): shift, then reduce when bit 7 falls out.
    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? IPM_GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ibex_ipm_mul_if.sv
// Issue/result bundle between the EX block and the IPM multiplier.
// Latency: n/a (wiring only).
// Backpressure: result is held while ipm_ready_id_i is low.
interface ibex_ipm_mul_if;
    import ibex_ipm_mul_pkg::*;

    ipm_op_e     ipm_operator_i;
    logic        ipm_en_i;
    logic        ipm_sel_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ipm_ready_id_i;
    logic [31:0] result_o;
    logic        valid_o;

    // EX-block side: issues the instruction and consumes the result.
    modport master (
        output ipm_operator_i, ipm_en_i, ipm_sel_i, a_i, b_i, ipm_ready_id_i,
        input  result_o, valid_o
    );

    // Multiplier side.
    modport slave (
        input  ipm_operator_i, ipm_en_i, ipm_sel_i, a_i, b_i, ipm_ready_id_i,
        output result_o, valid_o
    );
endinterface

// File: rtl/ibex_ipm_gf_step.sv
// One MSB-first shift-and-add step of a GF(2^8) multiply: acc' = xtime(acc) ^ (bit ? a : 0).
// Latency: combinational.
// Backpressure: none.
module ibex_ipm_gf_step
    import ibex_ipm_mul_pkg::*;
(
    input  logic [7:0] acc,
    input  logic [7:0] a,
    input  logic       b_bit,
    output logic [7:0] acc_next
);

    assign acc_next = gf_xtime(acc) ^ (b_bit ? a : 8'h00);

endmodule

// File: rtl/ibex_ipm_mul.sv
// Iterative 4-lane GF(2^8) multiplier (MUL / SQR / inner product) for IPM instructions.
// Latency: 8/BitsPerCycle CALC cycles, valid_o one cycle after the last step; operand-independent.
// Backpressure: result and valid_o are held in DONE until ipm_ready_id_i or en drops.
module ibex_ipm_mul
    import ibex_ipm_mul_pkg::*;
#(
    parameter int unsigned BitsPerCycle = 1,
    parameter bit          SecureClear  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    ibex_ipm_mul_if.slave   ipm
);

    localparam int unsigned Steps   = 8 / BitsPerCycle;
    localparam logic [2:0]  CntLast = 3'(Steps - 1);

    if (!(BitsPerCycle == 1 || BitsPerCycle == 2 || BitsPerCycle == 4 || BitsPerCycle == 8))
    begin : g_bad_bits_per_cycle
        $error("ibex_ipm_mul: BitsPerCycle must be 1, 2, 4 or 8");
    end

    ipm_state_e      state_q, state_d;
    ipm_op_e         op_q;
    logic [2:0]      cnt_q;
    logic [31:0]     a_q, b_q, b_shift;
    logic [3:0][7:0] acc_q, acc_calc;
    logic [31:0]     result_q;
    logic            valid_q;
    logic            start, last_step;
    logic [7:0]      ip_fold;

    assign start     = ipm.ipm_en_i && ipm.ipm_sel_i;
    assign last_step = (cnt_q == CntLast);
    assign ip_fold   = acc_calc[0] ^ acc_calc[1] ^ acc_calc[2] ^ acc_calc[3];

    // Per lane, chain BitsPerCycle steps; b_q is shifted so its lane MSB is always the next bit.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] chain [BitsPerCycle+1];
        assign chain[0] = acc_q[l];
        for (genvar j = 0; j < BitsPerCycle; j++) begin : g_step
            ibex_ipm_gf_step u_step (
                .acc      (chain[j]),
                .a        (a_q[8*l +: 8]),
                .b_bit    (b_q[8*l + 7 - j]),
                .acc_next (chain[j+1])
            );
        end
        assign acc_calc[l]       = chain[BitsPerCycle];
        assign b_shift[8*l +: 8] = b_q[8*l +: 8] << BitsPerCycle;
    end

    // Next-state: en low aborts CALC and counts as consumption in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IPM_IDLE: if (start) state_d = IPM_CALC;
            IPM_CALC: begin
                if (!ipm.ipm_en_i)   state_d = IPM_IDLE;
                else if (last_step)  state_d = IPM_DONE;
            end
            IPM_DONE: if (ipm.ipm_ready_id_i || !ipm.ipm_en_i) state_d = IPM_IDLE;
            default:  state_d = IPM_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IPM_IDLE;
        else         state_q <= state_d;
    end

    // Operand latch, per-cycle accumulate, result load and optional scrubbing on exit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= IPM_OP_MUL;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state_d == IPM_DONE);
            unique case (state_q)
                IPM_IDLE: begin
                    if (start) begin
                        op_q  <= ipm.ipm_operator_i;
                        a_q   <= ipm.a_i;
                        b_q   <= (ipm.ipm_operator_i == IPM_OP_SQR) ? ipm.a_i : ipm.b_i;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                IPM_CALC: begin
                    if (!ipm.ipm_en_i) begin
                        cnt_q <= '0;
                        if (SecureClear) begin
                            a_q   <= '0;
                            b_q   <= '0;
                            acc_q <= '0;
                        end
                    end else begin
                        acc_q <= acc_calc;
                        b_q   <= b_shift;
                        if (last_step) begin
                            cnt_q    <= '0;
                            result_q <= (op_q == IPM_OP_IP) ? {24'b0, ip_fold} : acc_calc;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                IPM_DONE: begin
                    if (state_d == IPM_IDLE && SecureClear) begin
                        a_q      <= '0;
                        b_q      <= '0;
                        acc_q    <= '0;
                        result_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ipm.result_o = result_q;
    assign ipm.valid_o  = valid_q;

endmodule
